fdma_rd_arbiter_4ch: RTL and testbench
======================================

// Module: fdma_rd_arbiter_4ch
// PURPOSE
// Read-side counterpart of the 4-channel FDMA write interconnect: four video read buffers (uidbuf readers) share one FDMA read port.
// Grants the FDMA to one requester at a time using round-robin arbitration.
// Forwards the granted channel's addr/size/request to the FDMA, and returns busy plus zero-latency rvalid to that channel only.
// Checks each burst's beat count and detects lost requests; error status is sticky.
// PARAMETERS
// AXI_DATA_WIDTH  128   FDMA/AXI data width
// AXI_ADDR_WIDTH  32    FDMA/AXI address width
// REQ_TIMEOUT     1024  max cycles from fdma_rareq=1 to fdma_rbusy=1 before abort; must be >=2
// PORTS
// ui_clk          in   1     system clock
// ui_rstn         in   1     async active-low reset
// fdma_raddr_n    in   AW    channel n (n=1..4) burst start address
// fdma_rareq_n    in   1     channel n read request, held until fdma_rbusy_n=1
// fdma_rsize_n    in   16    channel n burst length in beats
// fdma_rbusy_n    out  1     channel n granted/transfer in progress
// fdma_rdata_n    out  DW    read data to channel n (broadcast of fdma_rdata)
// fdma_rvalid_n   out  1     channel n read beat valid
// fdma_raddr      out  AW    FDMA read address
// fdma_rareq      out  1     FDMA read request
// fdma_rsize      out  16    FDMA burst length
// fdma_rbusy      in   1     FDMA read busy
// fdma_rdata      in   DW    FDMA read data
// fdma_rvalid     in   1     FDMA read beat valid
// grant_id        out  2     last/current granted channel minus 1 (0..3)
// rd_err          out  4     sticky per-channel error: timeout or beat-count mismatch
// BEHAVIOUR
// - Clocking: single clock ui_clk. Reset: asynchronous, active-low ui_rstn.
// - Reset values: fdma_raddr=0, fdma_rareq=0, fdma_rsize=0, all fdma_rbusy_n=0, grant_id=0, rd_err=0.
//   Internal: rr_ptr=3, so channel 1 has top priority after reset.
// - FSM states: IDLE, REQ, XFER. Any undefined state returns to IDLE.
// - IDLE:
//   - Scan requests in order rr_ptr+1, rr_ptr+2, ... (mod 4); take the first fdma_rareq_n=1.
//   - On the next edge: register fdma_raddr_n/fdma_rsize_n onto the FDMA port, set fdma_rareq=1, fdma_rbusy_n=1, grant_id=n-1, rr_ptr=n-1, clear beat_cnt; go to REQ.
// - REQ:
//   - Hold addr/size/rareq.
//   - fdma_rbusy=1 -> fdma_rareq=0 on the next edge; go to XFER.
//   - After REQ_TIMEOUT cycles in REQ with no busy -> fdma_rareq=0, fdma_rbusy_n=0, rd_err[n-1]=1; go to IDLE.
// - XFER:
//   - Sampled fdma_rbusy=0 -> fdma_rbusy_n=0 on the next edge; go to IDLE.
//   - At that exit, beat_cnt!=fdma_rsize (including beats counted in the exit cycle) -> rd_err[n-1]=1.
// - rvalid routing is combinational, zero latency:
//   - fdma_rvalid_n = fdma_rvalid & (state!=IDLE) & (grant_id==n-1).
//   - Non-granted channels read 0; all channels read 0 in IDLE.
//   - fdma_rdata_n = fdma_rdata, wired to all channels.
// - beat_cnt: 17 bits, +1 per fdma_rvalid in REQ/XFER, saturates at 0x1FFFF.
// - Each grant serves one burst. Minimum gap between grants is 1 IDLE cycle.
//   A channel still requesting after completion waits behind the other pending channels.
// - A request deasserted by a channel while in IDLE is simply not granted. Request changes after grant are ignored; inputs are latched.
// - fdma_rsize_n=0: granted as-is; any beat received sets rd_err.
// - rd_err is cleared only by reset.
// - Reset mid-burst: all outputs return to reset values asynchronously. The FDMA side must also be reset.
// TESTING
// 1. ch2 only: addr=0x1000, size=480; FDMA gives busy 3 cycles after rareq, then 480 rvalid beats.
//    -> fdma_raddr=0x1000, fdma_rsize=480, rareq drops after busy, fdma_rvalid_2 pulses 480 times.
//    -> fdma_rvalid_1/3/4 stay 0; rd_err=0; grant_id=1.
// 2. All four request at reset release and stay asserted -> grant order 1,2,3,4,1,...; exactly one fdma_rbusy_n high at a time.
// 3. After ch3 is served, ch3 and ch1 both request -> ch4 is checked first (not requesting), then ch1 granted before ch3.
// 4. ch4 request, fdma_rbusy held 0 -> fdma_rareq falls after 1024 cycles, rd_err=4'b1000, FSM in IDLE, next request served normally.
// 5. ch1 size=64, FDMA returns 65 beats -> rd_err[0]=1 after busy falls; other bits stay 0.
// 6. Assert ui_rstn=0 mid-XFER on ch2 -> fdma_rareq=0, fdma_rbusy_2=0, fdma_rvalid_2=0 immediately.
//    After release, a ch2 re-request is granted first (rr_ptr=3).

Source files
------------

// File: rtl/fdma_rd_arbiter_4ch.sv
// Round-robin arbiter sharing one FDMA read port among four video read buffers.
// Routes read beats to the granted channel only; flags lost requests and beat-count mismatches.
module fdma_rd_arbiter_4ch #(
    parameter int AXI_DATA_WIDTH = 128,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int REQ_TIMEOUT    = 1024
) (
    input  logic                      ui_clk,
    input  logic                      ui_rstn,

    input  logic [AXI_ADDR_WIDTH-1:0] fdma_raddr_1,
    input  logic                      fdma_rareq_1,
    input  logic [15:0]               fdma_rsize_1,
    output logic                      fdma_rbusy_1,
    output logic [AXI_DATA_WIDTH-1:0] fdma_rdata_1,
    output logic                      fdma_rvalid_1,

    input  logic [AXI_ADDR_WIDTH-1:0] fdma_raddr_2,
    input  logic                      fdma_rareq_2,
    input  logic [15:0]               fdma_rsize_2,
    output logic                      fdma_rbusy_2,
    output logic [AXI_DATA_WIDTH-1:0] fdma_rdata_2,
    output logic                      fdma_rvalid_2,

    input  logic [AXI_ADDR_WIDTH-1:0] fdma_raddr_3,
    input  logic                      fdma_rareq_3,
    input  logic [15:0]               fdma_rsize_3,
    output logic                      fdma_rbusy_3,
    output logic [AXI_DATA_WIDTH-1:0] fdma_rdata_3,
    output logic                      fdma_rvalid_3,

    input  logic [AXI_ADDR_WIDTH-1:0] fdma_raddr_4,
    input  logic                      fdma_rareq_4,
    input  logic [15:0]               fdma_rsize_4,
    output logic                      fdma_rbusy_4,
    output logic [AXI_DATA_WIDTH-1:0] fdma_rdata_4,
    output logic                      fdma_rvalid_4,

    output logic [AXI_ADDR_WIDTH-1:0] fdma_raddr,
    output logic                      fdma_rareq,
    output logic [15:0]               fdma_rsize,
    input  logic                      fdma_rbusy,
    input  logic [AXI_DATA_WIDTH-1:0] fdma_rdata,
    input  logic                      fdma_rvalid,

    output logic [1:0]                grant_id,
    output logic [3:0]                rd_err
);

    localparam int TW = (REQ_TIMEOUT > 2) ? $clog2(REQ_TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(REQ_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_XFER = 2'd2
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [1:0]                r_rr_ptr;
    logic [1:0]                r_gid;
    logic [3:0]                r_busy_ch;
    logic [3:0]                r_err;
    logic [AXI_ADDR_WIDTH-1:0] r_raddr;
    logic [15:0]               r_rsize;
    logic                      r_rareq;
    logic [16:0]               r_beat_cnt;
    logic [TW-1:0]             r_tmo_cnt;

    logic [3:0]                w_req;
    logic                      w_found;
    logic [1:0]                w_sel;
    logic [AXI_ADDR_WIDTH-1:0] w_sel_addr;
    logic [15:0]               w_sel_size;
    logic [16:0]               w_beat_nxt;
    logic                      w_size_err;
    logic                      w_tmo_hit;
    logic                      w_active;

    assign w_req = {fdma_rareq_4, fdma_rareq_3, fdma_rareq_2, fdma_rareq_1};

    // Search starts just after the last granted channel so every requester gets a turn.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int unsigned i = 1; i <= 4; i++) begin
            if (!w_found && w_req[r_rr_ptr + 2'(i)]) begin
                w_found = 1'b1;
                w_sel   = r_rr_ptr + 2'(i);
            end
        end
    end

    always_comb begin
        w_sel_addr = fdma_raddr_1;
        w_sel_size = fdma_rsize_1;
        case (w_sel)
            2'd1: begin w_sel_addr = fdma_raddr_2; w_sel_size = fdma_rsize_2; end
            2'd2: begin w_sel_addr = fdma_raddr_3; w_sel_size = fdma_rsize_3; end
            2'd3: begin w_sel_addr = fdma_raddr_4; w_sel_size = fdma_rsize_4; end
            default: ;
        endcase
    end

    assign w_beat_nxt = (fdma_rvalid && (r_beat_cnt != '1)) ? r_beat_cnt + 17'd1 : r_beat_cnt;
    assign w_size_err = (w_beat_nxt != {1'b0, r_rsize});
    assign w_tmo_hit  = (r_tmo_cnt == TMO_LAST);

    always_ff @(posedge ui_clk or negedge ui_rstn) begin
        if (!ui_rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_found) w_state_nxt = S_REQ;
            end
            S_REQ: begin
                if (fdma_rbusy)     w_state_nxt = S_XFER;
                else if (w_tmo_hit) w_state_nxt = S_IDLE;
            end
            S_XFER: begin
                if (!fdma_rbusy) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge ui_clk or negedge ui_rstn) begin
        if (!ui_rstn) begin
            r_rr_ptr   <= 2'd3;
            r_gid      <= '0;
            r_busy_ch  <= '0;
            r_err      <= '0;
            r_raddr    <= '0;
            r_rsize    <= '0;
            r_rareq    <= 1'b0;
            r_beat_cnt <= '0;
            r_tmo_cnt  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_raddr    <= w_sel_addr;
                        r_rsize    <= w_sel_size;
                        r_rareq    <= 1'b1;
                        r_busy_ch  <= 4'b0001 << w_sel;
                        r_gid      <= w_sel;
                        r_rr_ptr   <= w_sel;
                        r_beat_cnt <= '0;
                        r_tmo_cnt  <= '0;
                    end
                end
                S_REQ: begin
                    r_beat_cnt <= w_beat_nxt;
                    if (fdma_rbusy) begin
                        r_rareq <= 1'b0;
                    end else if (w_tmo_hit) begin
                        r_rareq       <= 1'b0;
                        r_busy_ch     <= '0;
                        r_err[r_gid]  <= 1'b1;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + TW'(1);
                    end
                end
                S_XFER: begin
                    r_beat_cnt <= w_beat_nxt;
                    if (!fdma_rbusy) begin
                        r_busy_ch <= '0;
                        if (w_size_err) r_err[r_gid] <= 1'b1;
                    end
                end
                default: begin
                    r_rareq   <= 1'b0;
                    r_busy_ch <= '0;
                end
            endcase
        end
    end

    assign w_active = (r_state != S_IDLE);

    assign fdma_raddr = r_raddr;
    assign fdma_rsize = r_rsize;
    assign fdma_rareq = r_rareq;
    assign grant_id   = r_gid;
    assign rd_err     = r_err;

    assign fdma_rbusy_1 = r_busy_ch[0];
    assign fdma_rbusy_2 = r_busy_ch[1];
    assign fdma_rbusy_3 = r_busy_ch[2];
    assign fdma_rbusy_4 = r_busy_ch[3];

    assign fdma_rvalid_1 = fdma_rvalid & w_active & (r_gid == 2'd0);
    assign fdma_rvalid_2 = fdma_rvalid & w_active & (r_gid == 2'd1);
    assign fdma_rvalid_3 = fdma_rvalid & w_active & (r_gid == 2'd2);
    assign fdma_rvalid_4 = fdma_rvalid & w_active & (r_gid == 2'd3);

    assign fdma_rdata_1 = fdma_rdata;
    assign fdma_rdata_2 = fdma_rdata;
    assign fdma_rdata_3 = fdma_rdata;
    assign fdma_rdata_4 = fdma_rdata;

endmodule

// File: tb/tb_fdma_rd_arbiter_4ch.sv
// Self-checking bench for fdma_rd_arbiter_4ch: transaction-level owner model, FDMA responder,
// directed scenarios plus randomized traffic.
module tb_fdma_rd_arbiter_4ch;

    localparam int DW  = 128;
    localparam int AW  = 32;
    localparam int TMO = 1024;

    logic ui_clk  = 1'b0;
    logic ui_rstn = 1'b0;
    always #5 ui_clk = ~ui_clk;

    logic [AW-1:0] ch_addr [4];
    logic [15:0]   ch_size [4];
    logic [3:0]    ch_req;
    logic [3:0]    sticky;

    logic          fdma_rbusy;
    logic          fdma_rvalid;
    logic [DW-1:0] fdma_rdata;

    logic          b1, b2, b3, b4, v1, v2, v3, v4;
    logic [DW-1:0] d1, d2, d3, d4;
    logic [AW-1:0] fdma_raddr;
    logic          fdma_rareq;
    logic [15:0]   fdma_rsize;
    logic [1:0]    grant_id;
    logic [3:0]    rd_err;

    logic [3:0] dut_busy;
    logic [3:0] dut_rvalid;
    assign dut_busy   = {b4, b3, b2, b1};
    assign dut_rvalid = {v4, v3, v2, v1};

    fdma_rd_arbiter_4ch #(
        .AXI_DATA_WIDTH(DW),
        .AXI_ADDR_WIDTH(AW),
        .REQ_TIMEOUT   (TMO)
    ) dut (
        .ui_clk       (ui_clk),
        .ui_rstn      (ui_rstn),
        .fdma_raddr_1 (ch_addr[0]), .fdma_rareq_1(ch_req[0]), .fdma_rsize_1(ch_size[0]),
        .fdma_rbusy_1 (b1), .fdma_rdata_1(d1), .fdma_rvalid_1(v1),
        .fdma_raddr_2 (ch_addr[1]), .fdma_rareq_2(ch_req[1]), .fdma_rsize_2(ch_size[1]),
        .fdma_rbusy_2 (b2), .fdma_rdata_2(d2), .fdma_rvalid_2(v2),
        .fdma_raddr_3 (ch_addr[2]), .fdma_rareq_3(ch_req[2]), .fdma_rsize_3(ch_size[2]),
        .fdma_rbusy_3 (b3), .fdma_rdata_3(d3), .fdma_rvalid_3(v3),
        .fdma_raddr_4 (ch_addr[3]), .fdma_rareq_4(ch_req[3]), .fdma_rsize_4(ch_size[3]),
        .fdma_rbusy_4 (b4), .fdma_rdata_4(d4), .fdma_rvalid_4(v4),
        .fdma_raddr   (fdma_raddr),
        .fdma_rareq   (fdma_rareq),
        .fdma_rsize   (fdma_rsize),
        .fdma_rbusy   (fdma_rbusy),
        .fdma_rdata   (fdma_rdata),
        .fdma_rvalid  (fdma_rvalid),
        .grant_id     (grant_id),
        .rd_err       (rd_err)
    );

    int n_checks = 0;
    int n_errs   = 0;

    // Model: who owns the port, whether it still waits for FDMA busy, beats seen so far.
    int            m_owner;
    bit            m_wait;
    int            m_wcnt;
    int            m_beats;
    int            m_last;
    logic [AW-1:0] m_addr;
    logic [15:0]   m_size;
    logic          m_rareq;
    logic [1:0]    m_gid;
    logic [3:0]    m_err;

    int  rsp_phase, rsp_cnt, rsp_left, rsp_delay, rsp_extra;
    bit  rsp_rand, rsp_nobusy, auto_en;

    int         rv_cnt [4];
    int         rq_cnt;
    int         max_busy;
    logic [3:0] prev_busy;
    int         glog[$];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1; m_wait = 0; m_wcnt = 0; m_beats = 0; m_last = 3;
        m_addr = '0; m_size = '0; m_rareq = 1'b0; m_gid = '0; m_err = '0;
    endtask

    task automatic model_update();
        if (!ui_rstn) begin
            model_reset();
        end else if (m_owner < 0) begin
            for (int k = 1; k <= 4; k++) begin
                if (m_owner < 0 && ch_req[(m_last + k) % 4]) begin
                    m_owner = (m_last + k) % 4;
                    m_last  = m_owner;
                    m_gid   = 2'(m_owner);
                    m_addr  = ch_addr[m_owner];
                    m_size  = ch_size[m_owner];
                    m_rareq = 1'b1;
                    m_wait  = 1;
                    m_wcnt  = 0;
                    m_beats = 0;
                end
            end
        end else begin
            if (fdma_rvalid && m_beats < 131071) m_beats++;
            if (m_wait) begin
                if (fdma_rbusy) begin
                    m_wait  = 0;
                    m_rareq = 1'b0;
                end else begin
                    m_wcnt++;
                    if (m_wcnt == TMO) begin
                        m_rareq        = 1'b0;
                        m_err[m_owner] = 1'b1;
                        m_owner        = -1;
                    end
                end
            end else if (!fdma_rbusy) begin
                if (m_beats != int'(m_size)) m_err[m_owner] = 1'b1;
                m_owner = -1;
            end
        end
    endtask

    task automatic compare_all();
        logic [3:0] eb;
        eb = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
        chk("raddr",    fdma_raddr, m_addr);
        chk("rsize",    fdma_rsize, m_size);
        chk("rareq",    fdma_rareq, m_rareq);
        chk("grant_id", grant_id,   m_gid);
        chk("rd_err",   rd_err,     m_err);
        chk("rbusy_n",  dut_busy,   eb);
        chk("rvalid_n", dut_rvalid, fdma_rvalid ? eb : 4'b0000);
        chk("rdata_n",  {d1 ^ fdma_rdata, d2 ^ fdma_rdata, d3 ^ fdma_rdata, d4 ^ fdma_rdata} == '0, 1'b1);
    endtask

    task automatic responder();
        int extra;
        case (rsp_phase)
            0: begin
                fdma_rbusy  = 1'b0;
                fdma_rvalid = 1'b0;
                if (fdma_rareq && !rsp_nobusy) begin
                    rsp_cnt   = rsp_rand ? int'($urandom_range(1, 4)) : rsp_delay;
                    rsp_phase = 1;
                end
            end
            1: begin
                fdma_rvalid = 1'b0;
                rsp_cnt--;
                if (rsp_cnt <= 0) begin
                    extra = rsp_extra;
                    if (rsp_rand) begin
                        case ($urandom_range(0, 9))
                            0:       extra = -1;
                            1:       extra = 1;
                            default: extra = 0;
                        endcase
                    end
                    fdma_rbusy = 1'b1;
                    rsp_left   = int'(fdma_rsize) + extra;
                    if (rsp_left < 0) rsp_left = 0;
                    rsp_phase  = 2;
                end
            end
            default: begin
                if (rsp_left == 0) begin
                    fdma_rbusy  = 1'b0;
                    fdma_rvalid = 1'b0;
                    rsp_phase   = 0;
                end else begin
                    fdma_rvalid = rsp_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
                    if (fdma_rvalid) begin
                        rsp_left--;
                        // Occasionally drop busy together with the final beat.
                        if (rsp_left == 0 && rsp_rand && $urandom_range(0, 1) == 1) begin
                            fdma_rbusy = 1'b0;
                            rsp_phase  = 0;
                        end
                    end
                end
            end
        endcase
    endtask

    task automatic drive();
        fdma_rdata = {$urandom, $urandom, $urandom, $urandom};
        if (!ui_rstn) begin
            rsp_phase = 0; fdma_rbusy = 1'b0; fdma_rvalid = 1'b0;
        end else begin
            responder();
        end
        for (int c = 0; c < 4; c++) begin
            if (ch_req[c] && dut_busy[c] && !sticky[c]) ch_req[c] = 1'b0;
            if (auto_en && !ch_req[c] && !dut_busy[c] && $urandom_range(0, 9) < 3) begin
                ch_req[c]  = 1'b1;
                ch_addr[c] = $urandom;
                ch_size[c] = 16'($urandom_range(0, 12));
            end
        end
    endtask

    task automatic step();
        @(negedge ui_clk);
        if (ui_rstn) begin
            compare_all();
            for (int c = 0; c < 4; c++) begin
                if (dut_rvalid[c]) rv_cnt[c]++;
                if (dut_busy[c] && !prev_busy[c]) glog.push_back(c);
            end
            prev_busy = dut_busy;
            if (fdma_rareq) rq_cnt++;
            if ($countones(dut_busy) > max_busy) max_busy = $countones(dut_busy);
        end
        @(posedge ui_clk);
        model_update();
        #1;
        drive();
    endtask

    task automatic clear_mon();
        for (int c = 0; c < 4; c++) rv_cnt[c] = 0;
        rq_cnt = 0; max_busy = 0; prev_busy = '0;
        glog.delete();
    endtask

    task automatic do_reset(input logic [3:0] req_at_release);
        ui_rstn = 1'b0;
        model_reset();
        rsp_phase = 0; fdma_rbusy = 1'b0; fdma_rvalid = 1'b0;
        ch_req = '0;
        repeat (3) step();
        clear_mon();
        ch_req  = req_at_release;
        ui_rstn = 1'b1;
    endtask

    task automatic wait_quiet(input string nm, input int maxc);
        int n;
        n = 0;
        while (!(m_owner < 0 && ch_req == '0 && rsp_phase == 0) && n < maxc) begin
            step();
            n++;
        end
        n_checks++;
        if (n >= maxc) begin
            n_errs++;
            $display("FAIL %s: wait expired after %0d cycles", nm, n);
        end
    endtask

    task automatic wait_grants(input string nm, input int k, input int maxc);
        int n;
        n = 0;
        while (glog.size() < k && n < maxc) begin
            step();
            n++;
        end
        n_checks++;
        if (n >= maxc) begin
            n_errs++;
            $display("FAIL %s: wait expired, %0d grants seen", nm, glog.size());
        end
    endtask

    initial begin
        int exp_order [5];
        int n;
        exp_order = '{0, 1, 2, 3, 0};
        for (int c = 0; c < 4; c++) begin ch_addr[c] = '0; ch_size[c] = '0; end
        ch_req = '0; sticky = '0; auto_en = 0;
        fdma_rbusy = 1'b0; fdma_rvalid = 1'b0; fdma_rdata = '0;
        rsp_phase = 0; rsp_cnt = 0; rsp_left = 0; rsp_delay = 3; rsp_extra = 0;
        rsp_rand = 0; rsp_nobusy = 0;
        model_reset();
        clear_mon();

        // Reset values
        repeat (2) @(posedge ui_clk);
        #1;
        chk("rst_raddr", fdma_raddr, 0);
        chk("rst_rareq", fdma_rareq, 0);
        chk("rst_rsize", fdma_rsize, 0);
        chk("rst_busy",  dut_busy,   0);
        chk("rst_gid",   grant_id,   0);
        chk("rst_err",   rd_err,     0);

        // 1: ch2 alone, 480 beats, busy 3 cycles after rareq
        do_reset(4'b0000);
        ch_addr[1] = 32'h0000_1000; ch_size[1] = 16'd480; ch_req[1] = 1'b1;
        wait_quiet("t1_done", 700);
        chk("t1_raddr",   fdma_raddr, 32'h1000);
        chk("t1_rsize",   fdma_rsize, 480);
        chk("t1_beats2",  rv_cnt[1],  480);
        chk("t1_others",  rv_cnt[0] + rv_cnt[2] + rv_cnt[3], 0);
        chk("t1_gid",     grant_id,   2'd1);
        chk("t1_err",     rd_err,     4'b0000);

        // 2: all four held from reset release
        for (int c = 0; c < 4; c++) ch_size[c] = 16'd3;
        sticky = 4'hF;
        do_reset(4'hF);
        wait_grants("t2_grants", 5, 300);
        for (int i = 0; i < 5; i++) chk("t2_order", glog[i], exp_order[i]);
        chk("t2_onehot", max_busy, 1);
        sticky = '0; ch_req = '0;
        wait_quiet("t2_done", 100);

        // 3: after ch3, ch1 and ch3 request together -> ch1 first
        do_reset(4'b0000);
        ch_size[2] = 16'd4; ch_req[2] = 1'b1;
        wait_quiet("t3_first", 100);
        glog.delete();
        ch_size[0] = 16'd2; ch_req[0] = 1'b1; ch_req[2] = 1'b1;
        wait_quiet("t3_done", 100);
        chk("t3_ngrants", glog.size(), 2);
        chk("t3_first",   glog[0], 0);
        chk("t3_second",  glog[1], 2);

        // 4: ch4 request never acknowledged
        do_reset(4'b0000);
        rsp_nobusy = 1; ch_size[3] = 16'd5; ch_req[3] = 1'b1;
        n = 0;
        while (!(rq_cnt > 0 && !fdma_rareq) && n < 1200) begin step(); n++; end
        chk("t4_wait",     n < 1200, 1'b1);
        chk("t4_rareq_cyc", rq_cnt,  TMO);
        chk("t4_err",       rd_err,  4'b1000);
        chk("t4_busy",      dut_busy, 4'b0000);
        rsp_nobusy = 0;
        ch_size[0] = 16'd8; ch_req[0] = 1'b1;
        wait_quiet("t4_next", 100);
        chk("t4_next_beats", rv_cnt[0], 8);
        chk("t4_next_err",   rd_err,    4'b1000);

        // 5: ch1 size 64, FDMA delivers 65
        do_reset(4'b0000);
        rsp_extra = 1; ch_size[0] = 16'd64; ch_req[0] = 1'b1;
        wait_quiet("t5_done", 200);
        chk("t5_beats", rv_cnt[0], 65);
        chk("t5_err",   rd_err,    4'b0001);
        rsp_extra = 0;

        // 6: reset in the middle of a ch2 burst
        do_reset(4'b0000);
        ch_addr[1] = 32'hABCD_0000; ch_size[1] = 16'd100; ch_req[1] = 1'b1;
        n = 0;
        while (rv_cnt[1] < 10 && n < 300) begin step(); n++; end
        chk("t6_wait", n < 300, 1'b1);
        fdma_rbusy = 1'b1; fdma_rvalid = 1'b1;
        ui_rstn = 1'b0;
        #1;
        chk("t6_rareq",  fdma_rareq, 0);
        chk("t6_busy2",  b2,         0);
        chk("t6_valid2", v2,         0);
        chk("t6_raddr",  fdma_raddr, 0);
        ch_size[1] = 16'd2; ch_size[2] = 16'd2;
        do_reset(4'b0110);
        wait_quiet("t6_done", 100);
        chk("t6_first", glog[0], 1);

        // Randomized traffic
        do_reset(4'b0000);
        rsp_rand = 1; auto_en = 1;
        repeat (3000) step();
        auto_en = 0;
        wait_quiet("rand_drain", 500);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
